mantis_sprite_addr_gen: RTL
===========================

// Module: mantis_sprite_addr_gen
// PURPOSE
//  Upstream stage of the palettized sprite path. Places a SPR_W x SPR_H animated sprite at a
//  movable screen position, generates the frame-relative ROM address for each DrawX/DrawY,
//  and steps through animation frames on vertical-sync boundaries. Feeds *_rom.address;
//  sprite_hit is timed to line up with the palette RGB that the downstream stage registers.
// PARAMETERS
//  SPR_W        54     sprite width, pixels
//  SPR_H        160    sprite height, pixels
//  NUM_FRAMES   2      animation frames, stored back-to-back in ROM
//  FRAME_TICKS  8      vsyncs each animation frame is held (>=1)
//  ADDR_W       15     ROM address width; must hold NUM_FRAMES*SPR_W*SPR_H-1
// PORTS
//  vga_clk      in   1       pixel clock; all state updates on posedge
//  reset_n      in   1       asynchronous, active-low reset
//  DrawX        in   10      current pixel column, 0..799
//  DrawY        in   10      current pixel row, 0..524
//  blank        in   1       1 = active video region
//  vs           in   1       vertical sync, active-low
//  pos_x        in   10      requested sprite left edge; sampled only at frame_tick
//  pos_y        in   10      requested sprite top edge; sampled only at frame_tick
//  flip         in   1       1 = mirror horizontally; sampled only at frame_tick
//  anim_start   in   1       1-cycle pulse: start animation
//  anim_loop    in   1       sampled with anim_start: 1 = loop, 0 = one-shot
//  anim_stop    in   1       1-cycle pulse: abort to IDLE, frame 0
//  rom_address  out  ADDR_W  ROM address, combinational from DrawX/DrawY and shadow registers
//  sprite_hit   out  1       registered: RGB leaving downstream this cycle belongs to the sprite
//  frame_idx    out  $clog2(NUM_FRAMES)  current animation frame
//  anim_busy    out  1       1 while the FSM is in PLAY
//  anim_done    out  1       1-cycle pulse when a one-shot finishes
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, tick counter 0, shadow pos/flip 0, vs_d 1.
//  frame_tick: vs_d registered from vs; frame_tick = vs_d & ~vs (falling edge, 1 cycle).
//  Shadow registers: pos_x, pos_y and flip are copied on frame_tick only, so there is no tearing
//    mid-frame. The address path uses only the shadow values.
//  Address: rx = {1'b0,DrawX} - {1'b0,sx}, ry = {1'b0,DrawY} - {1'b0,sy}, both 11-bit signed.
//    hit_c = blank & rx>=0 & rx<SPR_W & ry>=0 & ry<SPR_H.
//    col = flip ? SPR_W-1-rx : rx.
//    rom_address = frame_idx*SPR_W*SPR_H + ry*SPR_W + col, truncated to ADDR_W.
//    When hit_c=0, rom_address = 0.
//  Clipping: right and bottom clipping follow from the bounds check. A shadow position >= 640/480
//    places the sprite fully off-screen, so no hit occurs.
//  Latency: sprite_hit <= hit_c on posedge, a 1-cycle delay. This matches the ROM read on negedge
//    plus the palette register on posedge downstream.
//  FSM IDLE -> PLAY on anim_start: frame_idx=0, tick=0, mode<=anim_loop.
//  FSM PLAY: on each frame_tick, tick++. When tick==FRAME_TICKS-1: tick<=0, and
//    if frame_idx<NUM_FRAMES-1: frame_idx++;
//    else if loop: frame_idx<=0;
//    else: go to IDLE, frame_idx<=0, anim_done=1 for one cycle.
//  anim_start during PLAY restarts from frame 0, tick 0, with the new mode.
//  anim_stop in any state goes to IDLE with frame_idx=0. If anim_start and anim_stop are
//    asserted in the same cycle, stop wins.
//  A frame_tick coinciding with start/stop is consumed by start/stop and is not counted.
//  An asynchronous reset mid-PLAY returns to the reset state immediately; no anim_done pulse.
//  NUM_FRAMES==1: the one-shot ends after FRAME_TICKS ticks; loop stays at frame 0.
// STRUCTURE
//  Package mantis_sprite_pkg holds: anim_state_t enum {IDLE, PLAY}; the constants
//    H_ACTIVE=640 and V_ACTIVE=480; the function spr_base(frame) returning frame*SPR_W*SPR_H.
//  Sub-module mantis_anim_fsm holds the FSM, tick counter, frame_idx and anim_done. Its inputs
//    are frame_tick, start, stop and loop.
//  The parent holds vs edge detection, the shadow registers, the address datapath and the
//    sprite_hit register.
// TESTING
//  1. Reset low mid-frame -> all outputs 0. After release with pos=(100,50): pixel (100,50) at
//     frame 0 -> rom_address=0, and sprite_hit=1 on the following cycle.
//  2. pos=(100,50), pixel (153,209) -> rom_address=8639. Pixel (154,209) -> hit_c=0, address 0.
//  3. flip=1, pixel (100,50) -> rom_address=53. Changing pos mid-frame has no effect until the
//     next vs falling edge.
//  4. pos=(620,400) -> hits only for x 620..639 and y 400..479; no wrap onto x 0..19.
//  5. One-shot, FRAME_TICKS=8 -> frame_idx goes to 1 after 8 vs edges. After 16 edges: IDLE,
//     anim_done pulses once, rom base returns to 0. Frame 1 base address = 8640.
//  6. Loop mode -> frame_idx wraps 1->0 and anim_busy stays 1. anim_start+anim_stop in the same
//     cycle -> IDLE. Reset during PLAY -> no anim_done pulse.

Source files
------------

// File: rtl/mantis_sprite_pkg.sv
// Shared types, screen constants and the per-frame ROM base helper for the sprite path.
package mantis_sprite_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } anim_state_t;

  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned SPR_W_DEF = 54;
  localparam int unsigned SPR_H_DEF = 160;

  // Frames are packed back-to-back in ROM, so a frame starts at frame*W*H.
  function automatic int unsigned spr_base(input int unsigned frame,
                                           input int unsigned spr_w = SPR_W_DEF,
                                           input int unsigned spr_h = SPR_H_DEF);
    return frame * spr_w * spr_h;
  endfunction

endpackage

// File: rtl/mantis_anim_fsm.sv
// Animation sequencer: holds each frame for FRAME_TICKS vsyncs, loops or ends one-shot.
module mantis_anim_fsm
  import mantis_sprite_pkg::*;
#(
  parameter int unsigned NUM_FRAMES  = 2,
  parameter int unsigned FRAME_TICKS = 8,
  parameter int unsigned FI_W        = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_tick,
  input  logic            start,
  input  logic            stop,
  input  logic            loop,
  output logic [FI_W-1:0] frame_idx,
  output logic            busy,
  output logic            done
);

  localparam int unsigned TICK_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
  localparam logic [FI_W-1:0]   FRAME_LAST = FI_W'(NUM_FRAMES - 1);

  anim_state_t       state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [FI_W-1:0]   frame_q, frame_d;
  logic              loop_q, loop_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      frame_q <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      frame_q <= frame_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

  // stop beats start, and both swallow any frame_tick landing in the same cycle.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    frame_d = frame_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      tick_d  = '0;
      frame_d = '0;
    end else if (start) begin
      state_d = PLAY;
      tick_d  = '0;
      frame_d = '0;
      loop_d  = loop;
    end else if (state_q == PLAY && frame_tick) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (frame_q < FRAME_LAST) begin
          frame_d = frame_q + 1'b1;
        end else if (loop_q) begin
          frame_d = '0;
        end else begin
          state_d = IDLE;
          frame_d = '0;
          done_d  = 1'b1;
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  assign frame_idx = frame_q;
  assign busy      = (state_q == PLAY);
  assign done      = done_q;

endmodule

// File: rtl/mantis_sprite_addr_gen.sv
// Sprite placement and ROM address generation; position/flip are latched once per vsync.
module mantis_sprite_addr_gen
  import mantis_sprite_pkg::*;
#(
  parameter int unsigned SPR_W       = 54,
  parameter int unsigned SPR_H       = 160,
  parameter int unsigned NUM_FRAMES  = 2,
  parameter int unsigned FRAME_TICKS = 8,
  parameter int unsigned ADDR_W      = 15
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              vs,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip,
  input  logic              anim_start,
  input  logic              anim_loop,
  input  logic              anim_stop,
  output logic [ADDR_W-1:0] rom_address,
  output logic              sprite_hit,
  output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] frame_idx,
  output logic              anim_busy,
  output logic              anim_done
);

  localparam int unsigned FI_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  logic       vs_d_q, vs_d_d;
  logic [9:0] sx_q, sx_d, sy_q, sy_d;
  logic       flip_q, flip_d;
  logic       sprite_hit_q, sprite_hit_d;
  logic       frame_tick;

  logic [10:0] rx, ry, col;
  logic        in_x, in_y, on_screen, hit_c;

  assign frame_tick = vs_d_q & ~vs;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_d_q       <= 1'b1;
      sx_q         <= '0;
      sy_q         <= '0;
      flip_q       <= 1'b0;
      sprite_hit_q <= 1'b0;
    end else begin
      vs_d_q       <= vs_d_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      flip_q       <= flip_d;
      sprite_hit_q <= sprite_hit_d;
    end
  end

  always_comb begin
    vs_d_d       = vs;
    sx_d         = sx_q;
    sy_d         = sy_q;
    flip_d       = flip_q;
    sprite_hit_d = hit_c;
    if (frame_tick) begin
      sx_d   = pos_x;
      sy_d   = pos_y;
      flip_d = flip;
    end
  end

  // rx/ry are 11-bit two's complement; bit 10 set means left of / above the sprite.
  always_comb begin
    rx        = {1'b0, DrawX} - {1'b0, sx_q};
    ry        = {1'b0, DrawY} - {1'b0, sy_q};
    in_x      = ~rx[10] && (rx < 11'(SPR_W));
    in_y      = ~ry[10] && (ry < 11'(SPR_H));
    on_screen = (32'(DrawX) < H_ACTIVE) && (32'(DrawY) < V_ACTIVE);
    // Gating with reset_n keeps the address bus quiet while the block is held in reset.
    hit_c     = reset_n & blank & in_x & in_y & on_screen;
    col       = flip_q ? (11'(SPR_W - 1) - rx) : rx;
    rom_address = '0;
    if (hit_c) begin
      rom_address = ADDR_W'(spr_base(32'(frame_idx), SPR_W, SPR_H)
                            + 32'(ry) * SPR_W + 32'(col));
    end
  end

  assign sprite_hit = sprite_hit_q;

  mantis_anim_fsm #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_TICKS(FRAME_TICKS),
    .FI_W       (FI_W)
  ) u_anim (
    .clk       (vga_clk),
    .rst_n     (reset_n),
    .frame_tick(frame_tick),
    .start     (anim_start),
    .stop      (anim_stop),
    .loop      (anim_loop),
    .frame_idx (frame_idx),
    .busy      (anim_busy),
    .done      (anim_done)
  );

endmodule
